fdivsqrt_iter_ctrl: RTL

Iteration controller for the shared divide/square-root unit. It sits directly upstream of the divsqrt postprocessing stage. It accepts FP or integer divide/sqrt starts in Execute and counts digit-recurrence iterations. It terminates early when the partial remainder goes to zero, then holds the result-ready handshake until Memory consumes it. It drives the busy, start and done strobes that gate the iteration datapath and the E/M pipeline.

---
 rtl/fdivsqrt_iter_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fdivsqrt_iter_ctrl.sv
// ---------------------------------------------------------------------------
// fdivsqrt_iter_ctrl
//
// Iteration controller for the shared divide/square-root unit, sitting just
// upstream of divsqrt postprocessing. It accepts FP or integer divide/sqrt
// starts in Execute and counts digit-recurrence iterations on a down-counter.
// When the op finishes, it holds the result-ready level until Memory consumes
// it. Busy, start and done strobes gate the iteration datapath and the E/M
// pipeline.
//
// Optional feature macro: DIVSQRT_EARLY_TERM_EN
//   defined   -> a zero partial remainder (WZeroE) seen in BUSY ends the op
//                early.
//   undefined -> WZeroE is ignored and every op runs its full iteration count.
//
// Parameters:
//   CNT_W  iteration counter width
//   CYC_S  iterations for single-precision div/sqrt
//   CYC_D  iterations for double-precision div/sqrt
//   LOGK   log2 of quotient bits retired per iteration (integer ops)
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   FDivStartE     FP div/sqrt request
//   IDivStartE     integer div/rem request
//   FmtE           0 = single, 1 = double (FP only)
//   SpecialCaseE   FP operand is NaN/Inf/zero; no iteration needed
//   IntCycDigitsE  quotient bits needed by the integer op
//   WZeroE         partial remainder is exactly zero this cycle
//   StallM         Memory stage stalled
//   FlushE         flush Execute
//   IFDivStartE    combinational accept strobe; loads datapath operands
//   FDivBusyE      unit occupied (stalls the pipeline)
//   FDivDoneE      result valid for postprocessing
//   CurIterE       remaining iterations (down-counter value)
// ---------------------------------------------------------------------------
module fdivsqrt_iter_ctrl #(
  parameter int CNT_W = 7,
  parameter int CYC_S = 13,
  parameter int CYC_D = 27,
  parameter int LOGK  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FDivStartE,
  input  logic             IDivStartE,
  input  logic             FmtE,
  input  logic             SpecialCaseE,
  input  logic [CNT_W-1:0] IntCycDigitsE,
  input  logic             WZeroE,
  input  logic             StallM,
  input  logic             FlushE,
  output logic             IFDivStartE,
  output logic             FDivBusyE,
  output logic             FDivDoneE,
  output logic [CNT_W-1:0] CurIterE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter load values hold N-1: the op spends N cycles in BUSY, the last
  // one with the counter at zero.
  localparam logic [CNT_W-1:0] LOAD_S = CNT_W'(CYC_S - 1);
  localparam logic [CNT_W-1:0] LOAD_D = CNT_W'(CYC_D - 1);

  // Rounding term for the integer ceiling divide by 2^LOGK.
  localparam int               ROUND_I = (1 << LOGK) - 1;
  localparam logic [CNT_W:0]   ROUND   = ROUND_I[CNT_W:0];

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic             w_accept;
  logic             w_early_term;
  logic [CNT_W:0]   w_int_sum;
  logic [CNT_W:0]   w_int_iters;
  logic [CNT_W:0]   w_int_n;
  logic [CNT_W-1:0] w_int_load;
  logic [CNT_W-1:0] w_fp_load;

  // -------------------------------------------------------------------------
  // Integer iteration count: N = max(1, ceil(digits / 2^LOGK)).
  // The sum is formed one bit wider so digits near the top of the range
  // cannot wrap. After the shift the result fits back into CNT_W bits.
  // -------------------------------------------------------------------------
  assign w_int_sum   = {1'b0, IntCycDigitsE} + ROUND;
  assign w_int_iters = w_int_sum >> LOGK;
  assign w_int_n     = (w_int_iters == '0) ? (CNT_W+1)'(1) : w_int_iters;
  assign w_int_load  = CNT_W'(w_int_n - (CNT_W+1)'(1));

  assign w_fp_load   = FmtE ? LOAD_D : LOAD_S;

  assign w_accept    = (FDivStartE | IDivStartE) & ~FlushE;

`ifdef DIVSQRT_EARLY_TERM_EN
  assign w_early_term = WZeroE;
`else
  // The port stays on the interface so both builds share one pinout.
  logic w_unused_wzero;
  assign w_unused_wzero = WZeroE;
  assign w_early_term   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, counter and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    IFDivStartE  = 1'b0;
    FDivBusyE    = 1'b0;
    FDivDoneE    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Gating with reset keeps the operand load strobe quiet while the
        // unit is held in reset, even if a start is still presented.
        IFDivStartE = w_accept & ~reset;
        if (w_accept) begin
          if (FDivStartE) begin
            // FP wins if both starts are high.
            if (SpecialCaseE) begin
              w_state_next = S_DONE;
              w_cnt_next   = '0;
            end else begin
              w_state_next = S_BUSY;
              w_cnt_next   = w_fp_load;
            end
          end else begin
            w_state_next = S_BUSY;
            w_cnt_next   = w_int_load;
          end
        end
      end

      S_BUSY: begin
        FDivBusyE = 1'b1;
        if (FlushE) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if ((r_cnt == '0) || w_early_term) begin
          // Counter freezes at its current value so postprocessing can see
          // how many iterations were actually retired.
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        FDivBusyE = 1'b1;
        FDivDoneE = 1'b1;
        if (FlushE) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (!StallM) begin
          // No accept here: the next op can start in the following IDLE
          // cycle at the earliest.
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign CurIterE = r_cnt;

endmodule
